// File: rtl/int_regfile_mp.sv
//------------------------------------------------------------------------------
// Module   : int_regfile_mp
// Purpose  : Multi-port integer register file, 2R/2W, pending-writeback
//            scoreboard bits and a self-clearing start-up/flush sequence.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_regfile_mp #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [XLEN-1:0]          rd_data_a,
    output logic [XLEN-1:0]          rd_data_b,
    input  logic                     wr0_en,
    input  logic [$clog2(NREGS)-1:0] wr0_addr,
    input  logic [XLEN-1:0]          wr0_data,
    input  logic                     wr1_en,
    input  logic [$clog2(NREGS)-1:0] wr1_addr,
    input  logic [XLEN-1:0]          wr1_data,
    input  logic                     busy_set_en,
    input  logic [$clog2(NREGS)-1:0] busy_set_addr,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic                     ready
);

    localparam int            AW         = $clog2(NREGS);
    localparam logic [AW-1:0] C_CNT_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] C_ZERO_A   = '0;
    localparam bit            C_ZERO_EN  = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_cnt;
    logic                 r_ready;
    logic [NREGS-1:0]     r_busy;
    logic [XLEN-1:0]      r_mem [NREGS];

    logic                 w_run;
    logic                 w_accept;
    logic                 w_wr0_we;
    logic                 w_wr1_we;
    logic                 w_clr_we;
    logic [NREGS-1:0]     w_busy_nxt;

    // A flush request takes the edge over any write presented alongside it.
    assign w_run    = (r_state == ST_RUN);
    assign w_accept = w_run && !clear_req;
    assign w_wr0_we = w_accept && wr0_en && !(C_ZERO_EN && (wr0_addr == C_ZERO_A));
    assign w_wr1_we = w_accept && wr1_en && !(C_ZERO_EN && (wr1_addr == C_ZERO_A));
    assign w_clr_we = reset && (r_state == ST_CLEAR);

    always_comb begin
        w_busy_nxt = r_busy;
        if (wr0_en) begin
            w_busy_nxt[wr0_addr] = 1'b0;
        end
        if (wr1_en) begin
            w_busy_nxt[wr1_addr] = 1'b0;
        end
        if (busy_set_en) begin
            w_busy_nxt[busy_set_addr] = 1'b1;
        end
        if (C_ZERO_EN) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= '0;
                        r_ready <= 1'b0;
                    end else begin
                        r_busy <= w_busy_nxt;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; the CLEAR walk zeroes it one entry per cycle.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr0_we) begin
                r_mem[wr0_addr] <= wr0_data;
            end
            if (w_wr1_we) begin
                r_mem[wr1_addr] <= wr1_data;
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (w_run && !(C_ZERO_EN && (rd_addr_a == C_ZERO_A))) begin
            if (wr1_en && (wr1_addr == rd_addr_a)) begin
                rd_data_a = wr1_data;
            end else if (wr0_en && (wr0_addr == rd_addr_a)) begin
                rd_data_a = wr0_data;
            end else begin
                rd_data_a = r_mem[rd_addr_a];
            end
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (w_run && !(C_ZERO_EN && (rd_addr_b == C_ZERO_A))) begin
            if (wr1_en && (wr1_addr == rd_addr_b)) begin
                rd_data_b = wr1_data;
            end else if (wr0_en && (wr0_addr == rd_addr_b)) begin
                rd_data_b = wr0_data;
            end else begin
                rd_data_b = r_mem[rd_addr_b];
            end
        end
    end

    assign busy_a = r_busy[rd_addr_a];
    assign busy_b = r_busy[rd_addr_b];
    assign ready  = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_int_regfile_mp.sv
//------------------------------------------------------------------------------
// Module   : tb_int_regfile_mp
// Purpose  : Scoreboard bench for int_regfile_mp against an array-based model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef struct {
        logic            rst_n;
        logic            clr;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   rb;
        logic            w0e;
        logic [AW-1:0]   w0a;
        logic [XLEN-1:0] w0d;
        logic            w1e;
        logic [AW-1:0]   w1a;
        logic [XLEN-1:0] w1d;
        logic            bse;
        logic [AW-1:0]   bsa;
    } stim_t;

    typedef struct {
        logic            rdy;
        logic [XLEN-1:0] da;
        logic [XLEN-1:0] db;
        logic            ba;
        logic            bb;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            clear_req = 1'b0;
    logic [AW-1:0]   rd_addr_a = '0, rd_addr_b = '0;
    logic [XLEN-1:0] rd_data_a, rd_data_b;
    logic            wr0_en = 1'b0, wr1_en = 1'b0;
    logic [AW-1:0]   wr0_addr = '0, wr1_addr = '0;
    logic [XLEN-1:0] wr0_data = '0, wr1_data = '0;
    logic            busy_set_en = 1'b0;
    logic [AW-1:0]   busy_set_addr = '0;
    logic            busy_a, busy_b, ready;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    // Reference model: storage array, pending bits, run flag, remaining clear cycles.
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy [NREGS];
    bit              m_run = 1'b0;
    int              m_left = NREGS;

    int_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset), .clear_req(clear_req),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .busy_a(busy_a), .busy_b(busy_b), .ready(ready)
    );

    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input stim_t s);
        if (!m_run || a == 0) return '0;
        if (s.w1e && s.w1a == a) return s.w1d;
        if (s.w0e && s.w0a == a) return s.w0d;
        return m_mem[a];
    endfunction

    task automatic m_edge(input stim_t s);
        if (!s.rst_n) begin
            m_run = 1'b0;
            m_left = NREGS;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else if (s.clr) begin
            m_run = 1'b0;
            m_left = NREGS;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (s.w0e && s.w0a != 0) m_mem[s.w0a] = s.w0d;
            if (s.w1e && s.w1a != 0) m_mem[s.w1a] = s.w1d;
            if (s.w0e) m_busy[s.w0a] = 1'b0;
            if (s.w1e) m_busy[s.w1a] = 1'b0;
            if (s.bse && s.bsa != 0) m_busy[s.bsa] = 1'b1;
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clock);
        reset = s.rst_n;       clear_req = s.clr;
        rd_addr_a = s.ra;      rd_addr_b = s.rb;
        wr0_en = s.w0e;        wr0_addr = s.w0a;   wr0_data = s.w0d;
        wr1_en = s.w1e;        wr1_addr = s.w1a;   wr1_data = s.w1d;
        busy_set_en = s.bse;   busy_set_addr = s.bsa;
        e.rdy = m_run;
        e.da  = m_read(s.ra, s);
        e.db  = m_read(s.rb, s);
        e.ba  = m_run && m_busy[s.ra];
        e.bb  = m_run && m_busy[s.rb];
        exp_q.push_back(e);
        m_edge(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.clr = 1'b0;
        s.ra = AW'($urandom_range(0, NREGS-1));
        s.rb = AW'($urandom_range(0, NREGS-1));
        s.w0e = 1'b0; s.w0a = '0; s.w0d = '0;
        s.w1e = 1'b0; s.w1a = '0; s.w1d = '0;
        s.bse = 1'b0; s.bsa = '0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s = idle();
        s.w0e = 1'($urandom_range(0, 1));
        s.w1e = 1'($urandom_range(0, 1));
        s.bse = 1'($urandom_range(0, 1));
        s.w0a = AW'($urandom_range(0, NREGS-1));
        s.w1a = ($urandom_range(0, 3) == 0) ? s.w0a : AW'($urandom_range(0, NREGS-1));
        s.bsa = ($urandom_range(0, 3) == 0) ? s.w0a : AW'($urandom_range(0, NREGS-1));
        s.w0d = {$urandom, $urandom};
        s.w1d = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: s.ra = s.w0a;
            1: s.ra = s.w1a;
            default: ;
        endcase
        if ($urandom_range(0, 2) == 0) s.rb = s.w1a;
        return s;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("ready",  XLEN'(ready),  XLEN'(e.rdy));
                chk("rd_a",   rd_data_a,     e.da);
                chk("rd_b",   rd_data_b,     e.db);
                chk("busy_a", XLEN'(busy_a), XLEN'(e.ba));
                chk("busy_b", XLEN'(busy_b), XLEN'(e.bb));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        // Let the held reset settle the DUT before any expectation is queued.
        repeat (2) @(posedge clock);
        repeat (3) begin s = idle(); s.rst_n = 1'b0; step(s); end
        // Start-up clear, with write/busy traffic that must be dropped.
        repeat (34) step(rnd());

        s = idle(); s.w0e = 1; s.w0a = 5; s.w0d = 64'hDEAD; s.ra = 5; step(s);
        s = idle(); s.ra = 5; step(s);
        s = idle(); s.w0e = 1; s.w0a = 7; s.w0d = 64'h1;
        s.w1e = 1; s.w1a = 7; s.w1d = 64'h2; s.ra = 7; step(s);
        s = idle(); s.ra = 7; step(s);
        s = idle(); s.w1e = 1; s.w1a = 0; s.w1d = 64'hFFFF; s.ra = 0; s.rb = 0; step(s);
        s = idle(); s.ra = 0; step(s);

        s = idle(); s.bse = 1; s.bsa = 9; s.ra = 9; step(s);
        s = idle(); s.ra = 9; s.w1e = 1; s.w1a = 9; s.w1d = 64'h99; step(s);
        s = idle(); s.ra = 9; step(s);
        s = idle(); s.bse = 1; s.bsa = 9; s.w0e = 1; s.w0a = 9; s.w0d = 64'hABC; step(s);
        s = idle(); s.ra = 9; s.rb = 9; step(s);
        s = idle(); s.bse = 1; s.bsa = 0; step(s);
        s = idle(); s.ra = 0; step(s);

        s = idle(); s.w0e = 1; s.w0a = 3; s.w0d = 64'h55; step(s);
        s = idle(); s.clr = 1; s.ra = 3; step(s);
        repeat (34) begin s = rnd(); s.clr = 1'($urandom_range(0, 1)); s.ra = 3; step(s); end

        s = idle(); s.clr = 1; step(s);
        repeat (10) step(rnd());
        s = idle(); s.rst_n = 1'b0; step(s);
        repeat (34) step(rnd());

        for (int i = 0; i < 2000; i++) begin
            s = rnd();
            if ($urandom_range(0, 199) == 0) begin
                s.clr = 1'b1; s.w0e = 0; s.w1e = 0; s.bse = 0;
            end
            if ($urandom_range(0, 499) == 0) s.rst_n = 1'b0;
            step(s);
        end

        repeat (2) @(negedge clock);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
